// File: rtl/riscv_pkg.sv
// Shared M-stage types: result-source encodings, FSM state encoding and the
// MEM/WB field bundle.
package riscv_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  typedef enum logic [0:0] {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mstate_t;

  typedef struct packed {
    logic        reg_write;
    logic        lui;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] ext_imm;
    logic [31:0] pc_plus4;
  } wb_fields_t;

  localparam wb_fields_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register. Loads a bubble whenever the M stage is stalled so a
// held instruction never writes back twice.
module mem_wb_register
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bubble,
  input  wb_fields_t d,
  output wb_fields_t q
);

  wb_fields_t q_r;

  // MEM/WB register update: reset, bubble insertion or normal load
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= WB_BUBBLE;
    end else if (bubble) begin
      q_r <= WB_BUBBLE;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/memory_stage.sv
// RISC-V M stage: data-memory req/ready handshake, stall generation and MEM/WB load.
// Optional bus-timeout abort enabled by defining MEM_TIMEOUT_EN.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        luiM,
  input  logic [4:0]  RDM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ExtImmM,
  input  logic [31:0] PCPlus4M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        luiW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RDW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ExtImmW,
  output logic [31:0] PCPlus4W,
  output logic        mem_error
);

  // The wait counter is 5 bits wide, so the abort point must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32) begin : g_bad_timeout
    $error("memory_stage: TIMEOUT_CYCLES must be in 1..32");
  end

  mstate_t    state_r;
  logic       acc_s;
  logic       req_raw_s;
  logic       stall_s;
  logic       timeout_s;
  logic       done_s;
  wb_fields_t wb_d_s;
  wb_fields_t wb_q_s;

  assign acc_s = MemWriteM | (ResultSrcM == RESULT_MEM);

`ifdef MEM_TIMEOUT_EN
  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYCLES - 1);

  logic [4:0] wait_cnt_r;
  logic       mem_error_r;

  assign timeout_s = (state_r == MS_WAIT) && !mem_ready && (wait_cnt_r == TIMEOUT_LAST);

  // Wait counter: held at zero in IDLE so it starts from zero on entry to WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 5'd0;
    end else if (state_r == MS_IDLE) begin
      wait_cnt_r <= 5'd0;
    end else begin
      wait_cnt_r <= wait_cnt_r + 5'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_error_r <= 1'b0;
    end else if (timeout_s) begin
      mem_error_r <= 1'b1;
    end else begin
      mem_error_r <= mem_error_r;
    end
  end

  assign mem_error = mem_error_r;
`else
  assign timeout_s = 1'b0;
  assign mem_error = 1'b0;
`endif

  assign done_s = mem_ready | timeout_s;

  // Bus request and stall decode from the current state
  always_comb begin
    req_raw_s = 1'b0;
    stall_s   = 1'b0;
    case (state_r)
      MS_IDLE: begin
        req_raw_s = acc_s;
        stall_s   = acc_s & ~mem_ready;
      end
      MS_WAIT: begin
        req_raw_s = 1'b1;
        stall_s   = ~done_s;
      end
      default: begin
        req_raw_s = 1'b0;
        stall_s   = 1'b0;
      end
    endcase
  end

  // Handshake FSM; a timeout completes the access exactly like mem_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MS_IDLE;
    end else begin
      case (state_r)
        MS_IDLE: state_r <= (acc_s && !mem_ready) ? MS_WAIT : MS_IDLE;
        MS_WAIT: state_r <= done_s ? MS_IDLE : MS_WAIT;
        default: state_r <= MS_IDLE;
      endcase
    end
  end

  assign mem_req   = req_raw_s & ~rst;
  assign mem_we    = MemWriteM;
  assign mem_addr  = ALUResultM;
  assign mem_wdata = WriteDataM;
  assign StallM    = stall_s;

  // Read data is only captured from a completing request; aborts and non-accesses give zero
  assign wb_d_s = '{
    reg_write:  RegWriteM,
    lui:        luiM,
    result_src: ResultSrcM,
    rd:         RDM,
    alu_result: ALUResultM,
    read_data:  (req_raw_s && mem_ready) ? mem_rdata : 32'h0000_0000,
    ext_imm:    ExtImmM,
    pc_plus4:   PCPlus4M
  };

  mem_wb_register u_mem_wb (
    .clk    (clk),
    .rst    (rst),
    .bubble (stall_s),
    .d      (wb_d_s),
    .q      (wb_q_s)
  );

  assign RegWriteW  = wb_q_s.reg_write;
  assign luiW       = wb_q_s.lui;
  assign ResultSrcW = wb_q_s.result_src;
  assign RDW        = wb_q_s.rd;
  assign ALUResultW = wb_q_s.alu_result;
  assign ReadDataW  = wb_q_s.read_data;
  assign ExtImmW    = wb_q_s.ext_imm;
  assign PCPlus4W   = wb_q_s.pc_plus4;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus hand-written
// multi-cycle sequences (wait states, reset mid-access, timeout when MEM_TIMEOUT_EN).
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, luiM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM, ExtImmM, PCPlus4M;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        StallM;
  logic        RegWriteW, luiW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RDW;
  logic [31:0] ALUResultW, ReadDataW, ExtImmW, PCPlus4W;
  logic        mem_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .luiM(luiM),
    .RDM(RDM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ExtImmM(ExtImmM),
    .PCPlus4M(PCPlus4M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .StallM(StallM),
    .RegWriteW(RegWriteW), .luiW(luiW), .ResultSrcW(ResultSrcW), .RDW(RDW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .ExtImmW(ExtImmW), .PCPlus4W(PCPlus4W),
    .mem_error(mem_error)
  );

  typedef struct {
    logic [1:0]  rs;
    logic        mw, rw, lui;
    logic [4:0]  rd;
    logic [31:0] alu, wd, imm, pc4;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req, e_we, e_stall, e_rw, e_lui;
    logic [1:0]  e_rs;
    logic [4:0]  e_rd;
    logic [31:0] e_alu, e_rdw, e_imm, e_pc4;
  } tv_t;

  tv_t vec [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rs, input logic mw, input logic rw, input logic lui,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] imm, input logic [31:0] pc4,
                       input logic rdy, input logic [31:0] rdata);
    ResultSrcM = rs;  MemWriteM  = mw;  RegWriteM = rw;  luiM = lui;
    RDM        = rd;  ALUResultM = alu; WriteDataM = wd; ExtImmM = imm;
    PCPlus4M   = pc4; mem_ready  = rdy; mem_rdata  = rdata;
  endtask

  initial begin
    // rs mw rw lui rd alu wd imm pc4 rdy rdata | req we stall rwW luiW rsW rdW aluW rdW imm pc4
    vec[0] = '{2'b01, 1'b0, 1'b1, 1'b0, 5'd10, 32'h40, 32'h0, 32'h40, 32'h104, 1'b1, 32'hDEADBEEF,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 5'd10, 32'h40, 32'hDEADBEEF, 32'h40, 32'h104};
    vec[1] = '{2'b00, 1'b0, 1'b1, 1'b0, 5'd3, 32'h7, 32'hAAAA, 32'h5, 32'h108, 1'b0, 32'hFFFFFFFF,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd3, 32'h7, 32'h0, 32'h5, 32'h108};
    vec[2] = '{2'b10, 1'b0, 1'b1, 1'b0, 5'd1, 32'h200, 32'h0, 32'h100, 32'h10C, 1'b1, 32'h55555555,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 5'd1, 32'h200, 32'h0, 32'h100, 32'h10C};
    vec[3] = '{2'b00, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0, 32'h0, 32'h12345000, 32'h110, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 5'd7, 32'h0, 32'h0, 32'h12345000, 32'h110};
    vec[4] = '{2'b00, 1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 32'hCAFEF00D, 32'h80, 32'h114, 1'b1, 32'h0BADF00D,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h80, 32'h0BADF00D, 32'h80, 32'h114};

    // Reset with a load presented: no request may escape during reset
    rst = 1'b1;
    drive(2'b01, 1'b0, 1'b1, 1'b0, 5'd4, 32'h40, 32'h0, 32'h0, 32'h4, 1'b0, 32'h0);
    @(negedge clk); #2;
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    check("reset_regwritew", {31'd0, RegWriteW}, 32'd0);
    check("reset_aluresultw", ALUResultW, 32'd0);
    check("reset_mem_error", {31'd0, mem_error}, 32'd0);

    // Single-cycle table: zero-wait accesses and non-access instructions
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(vec[i].rs, vec[i].mw, vec[i].rw, vec[i].lui, vec[i].rd, vec[i].alu, vec[i].wd,
            vec[i].imm, vec[i].pc4, vec[i].rdy, vec[i].rdata);
      #2;
      check($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vec[i].e_req});
      check($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vec[i].e_we});
      check($sformatf("v%0d_stall", i), {31'd0, StallM}, {31'd0, vec[i].e_stall});
      check($sformatf("v%0d_mem_addr", i), mem_addr, vec[i].alu);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, vec[i].wd);
      @(posedge clk); #1;
      check($sformatf("v%0d_regwritew", i), {31'd0, RegWriteW}, {31'd0, vec[i].e_rw});
      check($sformatf("v%0d_luiw", i), {31'd0, luiW}, {31'd0, vec[i].e_lui});
      check($sformatf("v%0d_resultsrcw", i), {30'd0, ResultSrcW}, {30'd0, vec[i].e_rs});
      check($sformatf("v%0d_rdw", i), {27'd0, RDW}, {27'd0, vec[i].e_rd});
      check($sformatf("v%0d_aluresultw", i), ALUResultW, vec[i].e_alu);
      check($sformatf("v%0d_readdataw", i), ReadDataW, vec[i].e_rdw);
      check($sformatf("v%0d_extimmw", i), ExtImmW, vec[i].e_imm);
      check($sformatf("v%0d_pcplus4w", i), PCPlus4W, vec[i].e_pc4);
    end

    // Store with 3 wait cycles: 3 stall cycles with bubbles, then completion
    @(negedge clk);
    drive(2'b00, 1'b1, 1'b0, 1'b0, 5'd2, 32'h44, 32'h12345678, 32'h44, 32'h118, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      #2;
      check($sformatf("sw_stall%0d", k), {31'd0, StallM}, 32'd1);
      check($sformatf("sw_req%0d", k), {31'd0, mem_req}, 32'd1);
      check($sformatf("sw_we%0d", k), {31'd0, mem_we}, 32'd1);
      @(posedge clk); #1;
      check($sformatf("sw_bubble_rw%0d", k), {31'd0, RegWriteW}, 32'd0);
      check($sformatf("sw_bubble_alu%0d", k), ALUResultW, 32'd0);
      check($sformatf("sw_bubble_rd%0d", k), {27'd0, RDW}, 32'd0);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #2;
    check("sw_done_stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    check("sw_done_aluw", ALUResultW, 32'h44);
    check("sw_done_regwritew", {31'd0, RegWriteW}, 32'd0);

    // Back-to-back loads against 1-wait memory
    @(negedge clk);
    drive(2'b01, 1'b0, 1'b1, 1'b0, 5'd5, 32'h100, 32'h0, 32'h0, 32'h11C, 1'b0, 32'h0);
    #2;
    check("lwa_stall", {31'd0, StallM}, 32'd1);
    @(posedge clk); #1;
    check("lwa_bubble", {31'd0, RegWriteW}, 32'd0);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    #2;
    check("lwa_done_stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    check("lwa_readdataw", ReadDataW, 32'h11111111);
    check("lwa_rdw", {27'd0, RDW}, 32'd5);
    check("lwa_regwritew", {31'd0, RegWriteW}, 32'd1);
    @(negedge clk);
    drive(2'b01, 1'b0, 1'b1, 1'b0, 5'd6, 32'h104, 32'h0, 32'h0, 32'h120, 1'b0, 32'h0);
    #2;
    check("lwb_stall", {31'd0, StallM}, 32'd1);
    check("lwb_addr", mem_addr, 32'h104);
    @(posedge clk); #1;
    check("lwb_bubble_rdw", {27'd0, RDW}, 32'd0);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h22222222;
    #2;
    check("lwb_done_stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    check("lwb_readdataw", ReadDataW, 32'h22222222);
    check("lwb_rdw", {27'd0, RDW}, 32'd6);

    // Reset while a load sits in WAIT: request drops, state returns to IDLE
    @(negedge clk);
    drive(2'b01, 1'b0, 1'b1, 1'b0, 5'd9, 32'h180, 32'h0, 32'h0, 32'h124, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rstwait_mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    check("rstwait_regwritew", {31'd0, RegWriteW}, 32'd0);
    check("rstwait_rdw", {27'd0, RDW}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 1'b0, 1'b1, 1'b0, 5'd8, 32'h33, 32'h0, 32'h0, 32'h128, 1'b0, 32'h0);
    #2;
    check("postrst_idle_req", {31'd0, mem_req}, 32'd0);
    check("postrst_idle_stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    check("postrst_aluw", ALUResultW, 32'h33);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_clears_aluw", ALUResultW, 32'd0);
    check("rst_clears_pc4w", PCPlus4W, 32'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // Timeout after 4 WAIT cycles: stall 4 cycles, abort cycle completes with zero data
    drive(2'b01, 1'b0, 1'b1, 1'b0, 5'd12, 32'h300, 32'h0, 32'h0, 32'h12C, 1'b0, 32'h77777777);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #2;
      check($sformatf("to_stall%0d", k), {31'd0, StallM}, 32'd1);
      check($sformatf("to_err_before%0d", k), {31'd0, mem_error}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk); #2;
    check("to_abort_stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    check("to_mem_error", {31'd0, mem_error}, 32'd1);
    check("to_readdataw", ReadDataW, 32'd0);
    check("to_rdw", {27'd0, RDW}, 32'd12);
    @(negedge clk);
    drive(2'b00, 1'b0, 1'b1, 1'b0, 5'd1, 32'h1, 32'h0, 32'h0, 32'h130, 1'b0, 32'h0);
    #2;
    check("to_req_dropped", {31'd0, mem_req}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("to_error_sticky", {31'd0, mem_error}, 32'd1);
`else
    // Without the timeout option a WAIT may last indefinitely and mem_error stays 0
    drive(2'b01, 1'b0, 1'b1, 1'b0, 5'd12, 32'h300, 32'h0, 32'h0, 32'h12C, 1'b0, 32'h77777777);
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      #2;
      check($sformatf("nto_stall%0d", k), {31'd0, StallM}, 32'd1);
      @(posedge clk); #1;
      check($sformatf("nto_err%0d", k), {31'd0, mem_error}, 32'd0);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #2;
    check("nto_done_stall", {31'd0, StallM}, 32'd0);
    @(posedge clk); #1;
    check("nto_readdataw", ReadDataW, 32'h77777777);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
